// File: rtl/instr_loader_pkg.sv
// ============================================================================
//  Module      : instr_loader_pkg
//  Description : Shared types and constants for the instruction loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_loader_pkg;

   localparam int LEN_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      CHECK  = 3'd3,
      LOAD   = 3'd4,
      CSUM   = 3'd5,
      DONE   = 3'd6,
      ERROR  = 3'd7
   } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_loader_csum.sv
// ============================================================================
//  Module      : loader_csum
//  Description : 8-bit XOR accumulator over the payload bytes of a frame.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module loader_csum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= 8'h00;
      end else if (clear) begin
         sum <= 8'h00;
      end else if (en) begin
         sum <= sum ^ din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
//  Module      : instr_loader
//  Description : Streams a length-prefixed byte frame into instruction memory
//                from address 0 while holding the CPU. Optional trailing XOR
//                checksum byte when CHECKSUM_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 12,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     s_valid,
   input  logic [DATA_WIDTH-1:0]    s_data,
   output logic                     s_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_hold,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   // Store capacity in bytes, one bit wider than the length field
   localparam logic [LEN_WIDTH:0] MAX_LEN = {{LEN_WIDTH{1'b0}}, 1'b1} << ADDRESS_WIDTH;

   state_t                   state;
   logic [DATA_WIDTH-1:0]    len_hi;
   logic [LEN_WIDTH-1:0]     remaining;
   logic [ADDRESS_WIDTH-1:0] count;
   logic                     xfer;

   assign xfer = s_valid & s_ready;

`ifdef CHECKSUM_EN
   logic [7:0] csum;
   logic       csum_clear;
   logic       csum_en;

   assign csum_clear = start && (state == IDLE || state == DONE || state == ERROR);
   assign csum_en    = xfer && (state == LOAD);

   loader_csum u_csum (
      .clk   (clk),
      .rst   (rst),
      .clear (csum_clear),
      .en    (csum_en),
      .din   (s_data),
      .sum   (csum)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         s_ready   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         len_hi    <= '0;
         remaining <= '0;
         count     <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state    <= LEN_HI;
                  s_ready  <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cpu_hold <= 1'b1;
                  count    <= '0;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_hi <= s_data;
                  state  <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  remaining <= {len_hi, s_data};
                  s_ready   <= 1'b0;
                  state     <= CHECK;
               end
            end
            CHECK: begin
               if (remaining == '0) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  busy     <= 1'b0;
               end else if (remaining[1:0] != 2'b00 || {1'b0, remaining} > MAX_LEN) begin
                  state <= ERROR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state   <= LOAD;
                  s_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (xfer) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= count;
                  mem_wdata <= s_data;
                  count     <= count + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
`ifdef CHECKSUM_EN
                     state <= CSUM;
`else
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     busy     <= 1'b0;
                     s_ready  <= 1'b0;
`endif
                  end
               end
            end
`ifdef CHECKSUM_EN
            CSUM: begin
               if (xfer) begin
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
                  if (s_data == csum) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERROR;
                     err   <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Randomised self-checking bench for instr_loader with a
//                frame-level reference model and an instruction RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_loader;

   localparam int AW  = 12;
   localparam int CAP = 1 << AW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           s_valid = 1'b0;
   logic [7:0]     s_data = 8'h00;
   logic           s_ready;
   logic           mem_we;
   logic [AW-1:0]  mem_addr;
   logic [7:0]     mem_wdata;
   logic           cpu_hold;
   logic           busy;
   logic           done;
   logic           err;

   int tests = 0;
   int fails = 0;
   int inv_bad = 0;
   bit abort = 0;

   int         obs_addr[$];
   int         obs_data[$];
   logic [7:0] pl[$];
   logic [7:0] ram [0:CAP-1];

   instr_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Instruction RAM model plus status invariants sampled mid-cycle
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         obs_addr.push_back(int'(mem_addr));
         obs_data.push_back(int'(mem_wdata));
         ram[mem_addr] = mem_wdata;
      end
      if (rst === 1'b0) begin
         if (cpu_hold !== ~done) inv_bad++;
         if (done === 1'b1 && err === 1'b1) inv_bad++;
         if (busy === 1'b0 && s_ready === 1'b1) inv_bad++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_s_ready"},   32'(s_ready),   32'd0);
      check({tag, "_mem_we"},    32'(mem_we),    32'd0);
      check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_cpu_hold"},  32'(cpu_hold),  32'd1);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_done"},      32'(done),      32'd0);
      check({tag, "_err"},       32'(err),       32'd0);
   endtask

   task automatic fill(input int n);
      pl.delete();
      repeat (n) pl.push_back(8'($urandom_range(255)));
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int n;
      if (abort) return;
      while ($urandom_range(99) < gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      while (s_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check("send_timeout", 32'd0, 32'd1);
         abort = 1;
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic pulse_start();
      obs_addr.delete();
      obs_data.delete();
      abort = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Frame-level model: a length is legal when zero or a multiple of 4 not
   // exceeding capacity; legal frames write payload byte i to address i.
   task automatic run_frame(input int len, input int gap, input logic [7:0] flip, input string tag);
      bit         valid_len;
      bit         exp_ok;
      int         exp_n;
      int         bad;
      int         k;
      logic [7:0] x;
      valid_len = (len == 0) || ((len % 4) == 0 && len <= CAP);
      exp_n     = valid_len ? len : 0;
      exp_ok    = valid_len;
      x = 8'h00;
      foreach (pl[i]) x ^= pl[i];
`ifdef CHECKSUM_EN
      if (len > 0 && flip != 8'h00) exp_ok = 0;
`else
      if (flip != 8'h00) x = x;
`endif
      pulse_start();
      send(8'(len >> 8), gap);
      send(8'(len), gap);
      if (valid_len && len > 0) begin
         for (int i = 0; i < len; i++) send(pl[i], gap);
`ifdef CHECKSUM_EN
         send(x ^ flip, gap);
`endif
      end
      k = 0;
      while (done !== 1'b1 && err !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      #1;
      check({tag, "_done"},     32'(done),     32'(exp_ok));
      check({tag, "_err"},      32'(err),      32'(!exp_ok));
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_ok));
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_nwrites"},  32'(obs_addr.size()), 32'(exp_n));
      bad = 0;
      for (int i = 0; i < obs_addr.size() && i < exp_n; i++) begin
         if (obs_addr[i] != i || obs_data[i] != int'(pl[i])) bad++;
      end
      check({tag, "_wr_seq"}, 32'(bad), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      // Two instructions, MSB first
      pl = '{8'h13, 8'h05, 8'h00, 8'h93, 8'h00, 8'h10, 8'h01, 8'h13};
      run_frame(8, 0, 8'h00, "two_instr");
      check("fetch0", {ram[0], ram[1], ram[2], ram[3]}, 32'h13050093);
      check("fetch4", {ram[4], ram[5], ram[6], ram[7]}, 32'h00100113);

      pl.delete();
      run_frame(6, 0, 8'h00, "len6");
      fill(16);
      run_frame(16, 0, 8'h00, "after_err");

      fill(CAP);
      run_frame(CAP, 0, 8'h00, "full");
      check("full_last_addr", 32'(obs_addr.size() > 0 ? obs_addr[obs_addr.size()-1] : -1), 32'hFFF);
      pl.delete();
      run_frame(CAP + 4, 0, 8'h00, "over");
      run_frame(0, 0, 8'h00, "len0");

      fill(16);
      run_frame(16, 50, 8'h00, "gaps16");

      for (int t = 0; t < 6; t++) begin
         fill(4 * $urandom_range(1, 16));
         run_frame(pl.size(), $urandom_range(0, 70), 8'h00, $sformatf("rnd%0d", t));
      end
      for (int t = 0; t < 3; t++) begin
         pl.delete();
         run_frame(4 * $urandom_range(0, 20) + $urandom_range(1, 3), 0, 8'h00, $sformatf("badlen%0d", t));
      end

      // Reset in the middle of a payload
      fill(16);
      pulse_start();
      send(8'h00, 0);
      send(8'h10, 0);
      for (int i = 0; i < 3; i++) send(pl[i], 0);
      #2 rst = 1'b1;
      #1 check_reset_vals("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_writes", 32'(obs_addr.size()), 32'd3);
      fill(16);
      run_frame(16, 20, 8'h00, "reload");

`ifdef CHECKSUM_EN
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_frame(4, 0, 8'h00, "csum_ok");
      run_frame(4, 0, 8'h01, "csum_bad");
      fill(32);
      run_frame(32, 30, 8'h80, "csum_bad_rnd");
`endif

      check("invariants", 32'(inv_bad), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
